// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX/MEM pipeline register with a one-entry skid buffer; EX_MEM_STALL_CNT_EN adds a stall counter
module ex_mem_skid_reg #(
    parameter int DATA_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int SEL_W     = 2
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 Valid_In,
    output logic                 Ready_Out,
    input  logic                 Flush,
    input  logic                 RegWriteEN_In,
    input  logic                 MemWriteEN_In,
    input  logic [SEL_W-1:0]     Mem2RegSEL_In,
    input  logic [DATA_W-1:0]    ALUResult_In,
    input  logic [DATA_W-1:0]    WriteData_In,
    input  logic [DATA_W-1:0]    PCPlus4_In,
    input  logic [REGADDR_W-1:0] RegWBAddr_In,
    output logic                 Valid_Out,
    input  logic                 Ready_In,
    output logic                 RegWriteEN_Out,
    output logic                 MemWriteEN_Out,
    output logic [SEL_W-1:0]     Mem2RegSEL_Out,
    output logic [DATA_W-1:0]    ALUResult_Out,
    output logic [DATA_W-1:0]    WriteData_Out,
    output logic [REGADDR_W-1:0] RegWBAddr_Out,
    output logic [DATA_W-1:0]    PCPlus4_Out
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]          StallCount_Out
`endif
);

    typedef struct packed {
        logic                 regwr;
        logic                 memwr;
        logic [SEL_W-1:0]     sel;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    wdata;
        logic [DATA_W-1:0]    pc4;
        logic [REGADDR_W-1:0] wbaddr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_e;
    logic   xfer_in;
    logic   xfer_out;

    // Pack the incoming EX fields so both entries load from one bundle
    always_comb begin
        in_e.regwr  = RegWriteEN_In;
        in_e.memwr  = MemWriteEN_In;
        in_e.sel    = Mem2RegSEL_In;
        in_e.alu    = ALUResult_In;
        in_e.wdata  = WriteData_In;
        in_e.pc4    = PCPlus4_In;
        in_e.wbaddr = RegWBAddr_In;
    end

    // Handshakes depend only on state (and RESET), never on Ready_In
    assign Ready_Out = (state != SKID) && !RESET;
    assign Valid_Out = (state != EMPTY);
    assign xfer_in   = Valid_In && Ready_Out;
    assign xfer_out  = Valid_Out && Ready_In;

    // Main entry always drives the MEM side; enables masked when nothing is valid
    assign RegWriteEN_Out = main_q.regwr && Valid_Out;
    assign MemWriteEN_Out = main_q.memwr && Valid_Out;
    assign Mem2RegSEL_Out = main_q.sel;
    assign ALUResult_Out  = main_q.alu;
    assign WriteData_Out  = main_q.wdata;
    assign PCPlus4_Out    = main_q.pc4;
    assign RegWBAddr_Out  = main_q.wbaddr;

    // Occupancy FSM: reset beats flush, flush beats any transfer and keeps data
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (Flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_q <= in_e;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_q <= in_e;
                    end else if (xfer_in) begin
                        skid_q <= in_e;
                        state  <= SKID;
                    end else if (xfer_out) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (xfer_out) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles the MEM stage refused a valid instruction
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stall_cnt <= 16'd0;
        end else if (Valid_Out && !Ready_In && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign StallCount_Out = stall_cnt;
`endif

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of ALU result, store data and PC+4 fields.
REQ-002 Parameter REGADDR_W, default 5: width of write-back register address.
REQ-003 Parameter SEL_W, default 2: width of Mem2Reg select field.
REQ-004 CLOCK  in  1  sole clock; all state updates on posedge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 Valid_In  in  1  EX stage presents a valid instruction.
REQ-007 Ready_Out  out  1  block can accept an instruction this cycle.
REQ-008 Flush  in  1  discard all held and incoming instructions.
REQ-009 RegWriteEN_In, MemWriteEN_In  in  1 each  register-write and memory-write enables.
REQ-010 Mem2RegSEL_In  in  SEL_W  write-back source select.
REQ-011 ALUResult_In, WriteData_In, PCPlus4_In  in  DATA_W each  EX results.
REQ-012 RegWBAddr_In  in  REGADDR_W  write-back register address.
REQ-013 Valid_Out  out  1  MEM stage sees a valid instruction.
REQ-014 Ready_In  in  1  MEM stage accepts the presented instruction.
REQ-015 RegWriteEN_Out, MemWriteEN_Out, Mem2RegSEL_Out, ALUResult_Out, WriteData_Out, RegWBAddr_Out, PCPlus4_Out  out  widths as inputs  registered fields.
REQ-016 StallCount_Out  out  16  stall-cycle counter (present only per REQ-033).

Function
REQ-017 Transfer in = Valid_In && Ready_Out; transfer out = Valid_Out && Ready_In.
REQ-018 Storage: one main entry driving outputs plus one skid entry; states EMPTY (none valid), FULL (main valid), SKID (both valid).
REQ-019 EMPTY: transfer in -> FULL, main loads inputs; else stay.
REQ-020 FULL: in && out -> FULL, main reloads; in only -> SKID, skid loads inputs; out only -> EMPTY; neither -> hold.
REQ-021 SKID: out -> FULL, main loads skid contents; no input accepted; else hold.
REQ-022 Ready_Out = 1 in EMPTY and FULL, 0 in SKID and while RESET high; derived from state only, no combinational path from Ready_In.
REQ-023 Valid_Out = 1 in FULL and SKID.
REQ-024 Latency: instruction accepted at edge N is visible on outputs after edge N when the main entry is free; strict FIFO order; no duplication or loss.
REQ-025 RegWriteEN_Out and MemWriteEN_Out forced 0 whenever Valid_Out = 0; other data outputs hold last loaded value.
REQ-026 Flush = 1 at edge: next state EMPTY, any same-cycle input discarded; Flush has priority over all transfers; data fields unchanged.
REQ-027 Held output fields stable while Valid_Out && !Ready_In.

Reset
REQ-028 RESET = 1 at edge: state EMPTY, all output fields 0, Valid_Out 0, StallCount_Out 0.
REQ-029 RESET has priority over Flush and all transfers; mid-operation reset drops all held instructions.
REQ-030 First cycle after RESET deasserts: Ready_Out = 1, Valid_Out = 0.

Configuration
REQ-031 Macro EX_MEM_STALL_CNT_EN selects the stall counter.
REQ-032 Defined: StallCount_Out increments by 1 each cycle with Valid_Out && !Ready_In, saturates at 16'hFFFF, cleared only by RESET (not Flush).
REQ-033 Not defined: StallCount_Out port and counter logic absent; all other behaviour identical.

Verification
REQ-034 Reset: RESET high one cycle with Valid_In=1 -> Valid_Out=0, all outputs 0, Ready_Out=1 next cycle.
REQ-035 Stream: Ready_In=1, Valid_In=1, ALUResult_In=1,2,3 on consecutive cycles -> ALUResult_Out=1,2,3 one cycle later each, Valid_Out continuous.
REQ-036 Backpressure: Ready_In=0, send A=0x10, B=0x20 -> Ready_Out=0 after B; raise Ready_In -> outputs 0x10 then 0x20, none lost.
REQ-037 Flush in SKID with Valid_In=1 -> next cycle Valid_Out=0, MemWriteEN_Out=0, RegWriteEN_Out=0, Ready_Out=1.
REQ-038 With EX_MEM_STALL_CNT_EN: hold Valid_Out=1, Ready_In=0 for 70000 cycles -> StallCount_Out=16'hFFFF; Flush leaves it unchanged.
